// File: rtl/turbo_out_sched.sv
// Output scheduler for a two-bank turbo encoder: drains each finished bank as
// its encoded beats followed by its trellis tail, serving banks strictly 0,1,0,1.
module turbo_out_sched #(
   parameter int unsigned SHORT_LEN = 1056,
   parameter int unsigned LONG_LEN  = 6144,
   parameter int unsigned TAIL_LEN  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] bank_done,
   input  logic [1:0] bank_long,
   input  logic       out_ready,
   output logic [1:0] rd_enc,
   output logic [1:0] rd_trl,
   output logic       sel_bank,
   output logic       sel_trl,
   output logic       out_valid,
   output logic       sop,
   output logic       eop,
   output logic [1:0] bank_free,
   output logic       ovf_err
);

   localparam int unsigned CNT_W = 13;
   localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
   localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      TRL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cur_bank_q, cur_bank_d;
   logic             cur_long_q, cur_long_d;
   logic             next_bank_q, next_bank_d;
   logic [1:0]       pending_q, pending_d;
   logic [1:0]       long_q, long_d;
   logic             ovf_q, ovf_d;

   logic             active;
   logic             accept;
   logic             enc_last;
   logic             trl_last;
   logic             launch;
   logic             launch_bank;
   logic [1:0]       cur_oh;

   // Length of the block in flight is frozen at launch so a colliding
   // bank_done on the same bank cannot change it mid-drain.
   assign active   = (state_q != IDLE);
   assign accept   = active && out_ready;
   assign enc_last = (cnt_q == (cur_long_q ? LONG_LAST : SHORT_LAST));
   assign trl_last = (cnt_q == TAIL_LAST);
   assign cur_oh   = cur_bank_q ? 2'b10 : 2'b01;

   // Next-state, bank bookkeeping and output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_bank_d  = cur_bank_q;
      cur_long_d  = cur_long_q;
      next_bank_d = next_bank_q;
      pending_d   = pending_q;
      long_d      = long_q;
      ovf_d       = ovf_q;
      launch      = 1'b0;
      launch_bank = next_bank_q;

      rd_enc      = 2'b00;
      rd_trl      = 2'b00;
      bank_free   = 2'b00;
      sel_bank    = 1'b0;
      sel_trl     = 1'b0;
      out_valid   = 1'b0;
      sop         = 1'b0;
      eop         = 1'b0;
      ovf_err     = 1'b0;

      case (state_q)
         IDLE: begin
            if (pending_q[next_bank_q]) begin
               launch      = 1'b1;
               launch_bank = next_bank_q;
            end
         end
         ENC: begin
            if (accept) begin
               if (enc_last) begin
                  state_d = TRL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         TRL: begin
            if (accept) begin
               if (trl_last) begin
                  // Hand over to the other bank with no bubble if it is ready
                  next_bank_d = ~next_bank_q;
                  if (pending_q[~cur_bank_q]) begin
                     launch      = 1'b1;
                     launch_bank = ~cur_bank_q;
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (launch) begin
         state_d                = ENC;
         cnt_d                  = '0;
         cur_bank_d             = launch_bank;
         cur_long_d             = long_q[launch_bank];
         pending_d[launch_bank] = 1'b0;
      end

      // A new completion always registers; colliding with queued or active work flags overflow
      for (int b = 0; b < 2; b++) begin
         if (bank_done[b]) begin
            if (pending_q[b] || (active && (cur_bank_q == 1'(b)))) begin
               ovf_d = 1'b1;
            end
            pending_d[b] = 1'b1;
            long_d[b]    = bank_long[b];
         end
      end

      if (rst_n) begin
         sel_bank = cur_bank_q;
         ovf_err  = ovf_q;
         if (active) begin
            out_valid = 1'b1;
            sel_trl   = (state_q == TRL);
            sop       = (state_q == ENC) && (cnt_q == '0);
            eop       = (state_q == TRL) && trl_last;
            if (out_ready) begin
               if (state_q == ENC) begin
                  rd_enc = cur_oh;
               end else begin
                  rd_trl = cur_oh;
                  if (trl_last) begin
                     bank_free = cur_oh;
                  end
               end
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cur_bank_q  <= 1'b0;
         cur_long_q  <= 1'b0;
         next_bank_q <= 1'b0;
         pending_q   <= 2'b00;
         long_q      <= 2'b00;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_bank_q  <= cur_bank_d;
         cur_long_q  <= cur_long_d;
         next_bank_q <= next_bank_d;
         pending_q   <= pending_d;
         long_q      <= long_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule

// File: doc/turbo_out_sched.md
TURBO_OUT_SCHED -- requirements
Module: turbo_out_sched

Interface
REQ-001 SHALL have parameter SHORT_LEN, default 1056, the short block length in ENC beats.
REQ-002 SHALL have parameter LONG_LEN, default 6144, the long block length in ENC beats.
REQ-003 SHALL have parameter TAIL_LEN, default 4, the number of trellis-tail beats per block.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state changes on its rising edge.
  rst_n  in  1  reset; synchronous, active-low.
  bank_done  in  2  one-cycle pulse per bank b: the writer finished one encoded block, plus its tail, into bank b.
  bank_long  in  2  length flag for bank b; sampled when bank_done[b]=1; 1 selects LONG_LEN, 0 selects SHORT_LEN.
  out_ready  in  1  downstream accepts the current beat.
  rd_enc  out  2  read strobe for bank b's encoded-bit FIFOs (show-ahead).
  rd_trl  out  2  read strobe for bank b's tail FIFOs.
  sel_bank  out  1  output mux select: bank being drained.
  sel_trl  out  1  output mux select: 1 = tail FIFOs, 0 = encoded FIFOs.
  out_valid  out  1  current beat is valid.
  sop  out  1  marks the first ENC beat of a block.
  eop  out  1  marks the last TRL beat of a block.
  bank_free  out  2  one-cycle pulse: bank b is fully drained and may be rewritten.
  ovf_err  out  1  sticky error: a bank_done pulse arrived for a bank still pending or being drained.

Function
REQ-005 SHALL keep a pending[1:0] flag and a captured long[1:0] flag per bank; bank_done[b] sets pending[b] and captures long[b]=bank_long[b].
REQ-006 SHALL implement the FSM states IDLE, ENC and TRL, with state, counter, cur_bank and flags all registered.
REQ-007 SHALL keep next_bank, reset to 0; banks are served strictly alternately 0,1,0,1 with no skipping.
REQ-008 In IDLE, if pending[next_bank]=1, SHALL go to ENC with cur_bank=next_bank, cnt=0 and pending[next_bank] cleared; otherwise SHALL stay in IDLE.
REQ-009 In IDLE, a pending bank other than next_bank SHALL wait and SHALL NOT be served out of order.
REQ-010 out_valid SHALL equal (state != IDLE); sel_bank=cur_bank; sel_trl=(state==TRL).
REQ-011 A beat is accepted when out_valid and out_ready are both 1; rd_enc[cur_bank] SHALL be 1 only when a beat is accepted in ENC, and rd_trl[cur_bank] only when a beat is accepted in TRL.
REQ-012 All other strobes SHALL be 0; strobes are combinational from registered state and out_ready, so the FIFO pops in the same cycle as the accepted beat.
REQ-013 With out_ready=0, the state, cnt and all outputs except the strobes SHALL hold; no beat is lost or duplicated.
REQ-014 cnt SHALL be a 13-bit counter; in ENC, L = LONG_LEN if long[cur_bank] else SHORT_LEN.
REQ-015 In ENC, an accepted beat with cnt<L-1 SHALL increment cnt; with cnt=L-1 it SHALL go to TRL with cnt=0.
REQ-016 In TRL, an accepted beat with cnt<TAIL_LEN-1 SHALL increment cnt; with cnt=TAIL_LEN-1 it SHALL pulse bank_free[cur_bank] and toggle next_bank.
REQ-017 After the last TRL beat, SHALL go directly to ENC on the other bank if that bank is pending (zero-bubble back-to-back), else to IDLE.
REQ-018 sop SHALL equal (state==ENC && cnt==0); eop SHALL equal (state==TRL && cnt==TAIL_LEN-1); both are qualified by out_valid.
REQ-019 A bank_done[b] arriving when pending[b]=1, or when b=cur_bank and state!=IDLE, SHALL set ovf_err; pending[b] SHALL be set; the block in progress SHALL be unaffected.
REQ-020 A bank_done on one bank SHALL be captured normally when it coincides with bank_free or the last beat of the other bank.
REQ-021 bank_done[1:0]=2'b11 in the same cycle SHALL be accepted for both banks.
REQ-022 Block latency SHALL be as follows: bank_done at cycle t with IDLE and matching next_bank gives out_valid=1, sop=1 at t+2; the pending flag is set at t+1 and the FSM launches at t+2.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force: state=IDLE, cnt=0, cur_bank=0, next_bank=0, pending=0, long=0, ovf_err=0.
REQ-024 Under reset, all outputs SHALL be 0.
REQ-025 Reset asserted mid-block SHALL abort without bank_free; the external FIFOs are cleared by the same reset.
REQ-026 bank_done during reset SHALL be ignored.

Verification
REQ-027 Short block: bank_done=01, bank_long=00, out_ready=1 -> sop at t+2; 1056 rd_enc[0] pulses, then 4 rd_trl[0]; eop and bank_free=01 on beat 1060; then IDLE.
REQ-028 Back-to-back: bank 0 long, then bank 1 short pending before bank 0 finishes -> 6144+4 beats on bank 0, then sop on bank 1 the next cycle with no out_valid gap; bank_free 01 then 10.
REQ-029 Backpressure: toggle out_ready pseudo-randomly -> rd strobe count equals accepted beat count (1060); cnt frozen while out_ready=0; sop/eop each once.
REQ-030 Order: bank_done=10 first, with next_bank=0 -> no output until bank_done=01; then bank 0 drains, then bank 1.
REQ-031 Overflow: second bank_done[0] while bank 0 is in ENC -> ovf_err=1 and sticky; the current block completes intact.
REQ-032 Reset mid-ENC at beat 500 -> next cycle out_valid=0, all strobes 0, pending=00, no bank_free; a new bank_done=01 restarts from sop.
